// File: rtl/m_ps2_host_fifo.sv
// PS/2 host controller: debounced line decoding, host-to-device transmit with
// request-to-send handshake, RX/TX byte FIFOs and sticky error reporting.
module m_ps2_host_fifo #(
    parameter int CLK_MHZ    = 100,
    parameter int RX_DEPTH   = 16,
    parameter int TX_DEPTH   = 4,
    parameter int DEB_CYCLES = 16,
    parameter int TIMEOUT_US = 2000
) (
    input  logic                        CLK,
    input  logic                        RST_X,
    inout  wire                         ps2_clk,
    inout  wire                         ps2_data,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_we,
    output logic                        tx_full,
    output logic [7:0]                  rx_data,
    input  logic                        rx_re,
    output logic                        rx_empty,
    output logic [$clog2(RX_DEPTH):0]   rx_count,
    input  logic                        inhibit,
    output logic                        busy,
    output logic [4:0]                  err,
    input  logic                        err_clr
);

    localparam int RX_AW   = $clog2(RX_DEPTH);
    localparam int TX_AW   = $clog2(TX_DEPTH);
    localparam int INH_CYC = 100 * CLK_MHZ;
    localparam int TO_CYC  = TIMEOUT_US * CLK_MHZ;
    localparam int TMR_MAX = (TO_CYC > INH_CYC) ? TO_CYC : INH_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);

    localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(TO_CYC - 1);
    localparam logic [TMR_W-1:0] INH_LAST    = TMR_W'(INH_CYC - 1);
    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RX_AW:0]   RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0]   TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);

    typedef enum logic [2:0] {
        IDLE, RX, TX_INH, TX_REQ, TX_BITS, TX_ACK, TX_END, INH
    } state_t;

    state_t           state;
    logic             clk_oe, data_oe;
    logic [3:0]       bit_cnt;
    logic [TMR_W-1:0] tmr;
    logic             rx_push_p1, par_err_p1, stop_err_p1, ack_err_p1, to_err_p1;
    logic [8:0]       rx_shift;
    logic [7:0]       tx_byte;

    logic             clk_s_p0, clk_s_p1, dat_s_p0, dat_s_p1;
    logic             deb_clk, deb_data, clk_fall;
    logic [DEB_W-1:0] deb_clk_cnt, deb_dat_cnt;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wptr, rx_rptr;
    logic             rx_full, rx_wr, rx_rd, ovf_set;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wptr, tx_rptr;
    logic [TX_AW:0]   tx_count;
    logic             tx_empty, tx_wr, tx_pop;

    logic             wd_active, wd_expire;

    assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
    assign ps2_data = data_oe ? 1'b0 : 1'bz;

    // Stage p0/p1: two-flop synchronizer; idles high like the released bus.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            clk_s_p0 <= 1'b1;
            clk_s_p1 <= 1'b1;
            dat_s_p0 <= 1'b1;
            dat_s_p1 <= 1'b1;
        end else begin
            clk_s_p0 <= ps2_clk;
            clk_s_p1 <= clk_s_p0;
            dat_s_p0 <= ps2_data;
            dat_s_p1 <= dat_s_p0;
        end
    end

    // Debouncers: output follows only after DEB_CYCLES differing samples in a row.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            deb_clk     <= 1'b1;
            deb_clk_cnt <= '0;
            clk_fall    <= 1'b0;
        end else begin
            clk_fall <= 1'b0;
            if (clk_s_p1 == deb_clk) begin
                deb_clk_cnt <= '0;
            end else if (deb_clk_cnt == DEB_LAST) begin
                deb_clk     <= clk_s_p1;
                deb_clk_cnt <= '0;
                clk_fall    <= deb_clk;
            end else begin
                deb_clk_cnt <= deb_clk_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            deb_data    <= 1'b1;
            deb_dat_cnt <= '0;
        end else begin
            if (dat_s_p1 == deb_data) begin
                deb_dat_cnt <= '0;
            end else if (deb_dat_cnt == DEB_LAST) begin
                deb_data    <= dat_s_p1;
                deb_dat_cnt <= '0;
            end else begin
                deb_dat_cnt <= deb_dat_cnt + 1'b1;
            end
        end
    end

    assign wd_active = (state == RX) || (state == TX_BITS) ||
                       (state == TX_ACK) || (state == TX_END);
    assign wd_expire = (tmr == TO_LAST);

    // Device start bits win over inhibit, which wins over a pending transmit.
    assign tx_pop = (state == IDLE) && !(clk_fall && !deb_data) &&
                    !inhibit && !tx_empty;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state       <= IDLE;
            clk_oe      <= 1'b0;
            data_oe     <= 1'b0;
            bit_cnt     <= '0;
            tmr         <= '0;
            rx_push_p1  <= 1'b0;
            par_err_p1  <= 1'b0;
            stop_err_p1 <= 1'b0;
            ack_err_p1  <= 1'b0;
            to_err_p1   <= 1'b0;
        end else begin
            rx_push_p1  <= 1'b0;
            par_err_p1  <= 1'b0;
            stop_err_p1 <= 1'b0;
            ack_err_p1  <= 1'b0;
            to_err_p1   <= 1'b0;
            if (wd_active) tmr <= clk_fall ? '0 : tmr + 1'b1;

            if (wd_active && !clk_fall && wd_expire) begin
                to_err_p1 <= 1'b1;
                state     <= IDLE;
                clk_oe    <= 1'b0;
                data_oe   <= 1'b0;
                tmr       <= '0;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tmr     <= '0;
                        bit_cnt <= '0;
                        if (clk_fall && !deb_data) begin
                            state <= RX;
                        end else if (inhibit) begin
                            state  <= INH;
                            clk_oe <= 1'b1;
                        end else if (!tx_empty) begin
                            state  <= TX_INH;
                            clk_oe <= 1'b1;
                        end
                    end
                    RX: begin
                        if (clk_fall) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd9) begin
                                state       <= IDLE;
                                par_err_p1  <= ~(^rx_shift);
                                stop_err_p1 <= ~deb_data;
                                rx_push_p1  <= (^rx_shift) & deb_data;
                            end
                        end
                    end
                    TX_INH: begin
                        if (tmr == INH_LAST) begin
                            tmr     <= '0;
                            data_oe <= 1'b1;
                            state   <= TX_REQ;
                        end else begin
                            tmr <= tmr + 1'b1;
                        end
                    end
                    TX_REQ: begin
                        clk_oe  <= 1'b0;
                        bit_cnt <= '0;
                        tmr     <= '0;
                        state   <= TX_BITS;
                    end
                    TX_BITS: begin
                        if (clk_fall) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt < 4'd8) begin
                                data_oe <= ~tx_byte[bit_cnt[2:0]];
                            end else if (bit_cnt == 4'd8) begin
                                data_oe <= ^tx_byte;
                            end else begin
                                data_oe <= 1'b0;
                                state   <= TX_ACK;
                            end
                        end
                    end
                    TX_ACK: begin
                        if (clk_fall) begin
                            ack_err_p1 <= deb_data;
                            state      <= TX_END;
                        end
                    end
                    TX_END: begin
                        if (deb_clk && deb_data) state <= IDLE;
                    end
                    INH: begin
                        if (!inhibit) begin
                            clk_oe <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Datapath registers carry no reset; validity is tracked by the control above.
    always_ff @(posedge CLK) begin
        if (rx_wr) rx_mem[rx_wptr] <= rx_shift[7:0];
        if (tx_wr) tx_mem[tx_wptr] <= tx_data;
        if (tx_pop) tx_byte <= tx_mem[tx_rptr];
        if (state == RX && clk_fall && bit_cnt != 4'd9)
            rx_shift <= {deb_data, rx_shift[8:1]};
    end

    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign rx_rd    = rx_re && !rx_empty;
    assign rx_wr    = rx_push_p1 && (!rx_full || rx_rd);
    assign ovf_set  = rx_push_p1 && !rx_wr;
    assign rx_data  = rx_mem[rx_rptr];

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_wr) rx_wptr <= rx_wptr + 1'b1;
            if (rx_rd) rx_rptr <= rx_rptr + 1'b1;
            case ({rx_wr, rx_rd})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    assign tx_full  = (tx_count == TX_FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign tx_wr    = tx_we && !tx_full;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_wr)  tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop) tx_rptr <= tx_rptr + 1'b1;
            case ({tx_wr, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            err <= '0;
        end else if (err_clr) begin
            err <= '0;
        end else begin
            err <= err | {ovf_set, to_err_p1, ack_err_p1, stop_err_p1, par_err_p1};
        end
    end

    assign busy = (state != IDLE) || !tx_empty;

endmodule

// File: tb/tb_m_ps2_host_fifo.sv
// Directed bench for m_ps2_host_fifo: a behavioural PS/2 device drives and
// samples the open-drain lines against hand-computed frames.
module tb_m_ps2_host_fifo;

    localparam int H = 30;

    logic       CLK = 1'b0;
    logic       RST_X = 1'b0;
    wire        ps2_clk;
    wire        ps2_data;
    logic [7:0] tx_data = 8'h00;
    logic       tx_we = 1'b0;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_re = 1'b0;
    logic       rx_empty;
    logic [4:0] rx_count;
    logic       inhibit = 1'b0;
    logic       busy;
    logic [4:0] err;
    logic       err_clr = 1'b0;

    logic dev_clk_lo = 1'b0;
    logic dev_dat_lo = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    assign ps2_clk  = dev_clk_lo ? 1'b0 : 1'bz;
    assign ps2_data = dev_dat_lo ? 1'b0 : 1'bz;
    pullup (ps2_clk);
    pullup (ps2_data);

    always #5 CLK = ~CLK;

    m_ps2_host_fifo #(
        .CLK_MHZ(100), .RX_DEPTH(16), .TX_DEPTH(4), .DEB_CYCLES(16), .TIMEOUT_US(100)
    ) dut (
        .CLK(CLK), .RST_X(RST_X), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .tx_data(tx_data), .tx_we(tx_we), .tx_full(tx_full),
        .rx_data(rx_data), .rx_re(rx_re), .rx_empty(rx_empty), .rx_count(rx_count),
        .inhibit(inhibit), .busy(busy), .err(err), .err_clr(err_clr)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Device-to-host frame: start, 8 data LSB-first, parity, stop.
    task automatic dev_send(input logic [7:0] b, input logic par_ok, input logic stop);
        logic [10:0] f;
        logic        par;
        par = ~^b;
        if (!par_ok) par = ~par;
        f = {stop, par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_dat_lo = ~f[i];
            cyc(H);
            dev_clk_lo = 1'b1;
            cyc(H);
            dev_clk_lo = 1'b0;
        end
        dev_dat_lo = 1'b0;
        cyc(40);
    endtask

    task automatic dev_partial(input logic [7:0] b, input int nbits);
        logic [8:0] f;
        f = {b, 1'b0};
        for (int i = 0; i <= nbits; i++) begin
            dev_dat_lo = ~f[i];
            cyc(H);
            dev_clk_lo = 1'b1;
            cyc(H);
            dev_clk_lo = 1'b0;
        end
        dev_dat_lo = 1'b0;
    endtask

    initial begin
        int          w;
        int          low;
        logic [9:0]  got;

        // Reset state
        cyc(5);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ps2_clk", ps2_clk, 1);
        chk("rst_ps2_data", ps2_data, 1);
        RST_X = 1'b1;
        cyc(40);

        // Single good frame 0x1C
        dev_send(8'h1C, 1'b1, 1'b1);
        chk("rx1_empty", rx_empty, 0);
        chk("rx1_data", rx_data, 8'h1C);
        chk("rx1_count", rx_count, 1);
        chk("rx1_err", err, 0);
        rx_re = 1'b1; cyc(1); rx_re = 1'b0;
        chk("rx1_pop_empty", rx_empty, 1);

        // Host transmit of 0xED
        tx_data = 8'hED; tx_we = 1'b1; cyc(1); tx_we = 1'b0;
        chk("tx_busy_queued", busy, 1);
        w = 0;
        while (ps2_clk !== 1'b0 && w < 200) begin cyc(1); w++; end
        chk("tx_clk_pulled", ps2_clk, 0);
        low = 0;
        while (ps2_clk === 1'b0 && low < 20000) begin cyc(1); low++; end
        chk("tx_inh_len_in_range", (low >= 10000 && low <= 10002), 1);
        chk("tx_start_bit", ps2_data, 0);
        cyc(H);
        for (int i = 0; i < 10; i++) begin
            dev_clk_lo = 1'b1;
            cyc(H);
            got[i] = ps2_data;
            dev_clk_lo = 1'b0;
            cyc(H);
        end
        dev_dat_lo = 1'b1;
        cyc(H);
        dev_clk_lo = 1'b1;
        cyc(H);
        dev_clk_lo = 1'b0;
        cyc(5);
        dev_dat_lo = 1'b0;
        cyc(60);
        chk("tx_data_bits", got[7:0], 8'hED);
        chk("tx_parity", got[8], 1);
        chk("tx_stop", got[9], 1);
        chk("tx_err", err, 0);
        chk("tx_busy_done", busy, 0);

        // 17 frames into a 16-deep FIFO
        for (int i = 0; i < 17; i++) dev_send(8'h10 + 8'(i), 1'b1, 1'b1);
        chk("ovf_count", rx_count, 16);
        chk("ovf_err", err, 5'b10000);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_readback", rx_data, 8'h10 + 8'(i));
            rx_re = 1'b1; cyc(1); rx_re = 1'b0;
        end
        chk("ovf_drained", rx_empty, 1);
        rx_re = 1'b1; cyc(1); rx_re = 1'b0;
        chk("pop_empty_ignored", rx_count, 0);
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;
        cyc(1);
        chk("err_cleared", err, 0);

        // Parity error, then stalled frame for the watchdog
        dev_send(8'h33, 1'b0, 1'b1);
        chk("par_err", err, 5'b00001);
        chk("par_no_push", rx_empty, 1);
        dev_partial(8'hA5, 3);
        cyc(9000);
        chk("to_not_yet", err, 5'b00001);
        chk("to_busy_in_frame", busy, 1);
        cyc(1500);
        chk("to_err", err, 5'b01001);
        chk("to_idle", busy, 0);
        chk("to_no_push", rx_empty, 1);
        chk("to_clk_released", ps2_clk, 1);

        // Stop-bit error
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;
        dev_send(8'h1C, 1'b1, 1'b0);
        chk("stop_err", err, 5'b00010);
        chk("stop_no_push", rx_empty, 1);
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;

        // inhibit raised mid-frame only takes effect once the frame is done
        fork
            dev_send(8'h5A, 1'b1, 1'b1);
            begin cyc(5 * H); inhibit = 1'b1; end
        join
        cyc(20);
        chk("inh_frame_data", rx_data, 8'h5A);
        chk("inh_frame_count", rx_count, 1);
        chk("inh_frame_err", err, 0);
        chk("inh_clk_held", ps2_clk, 0);
        for (int i = 0; i < 5; i++) begin
            tx_data = 8'h40 + 8'(i); tx_we = 1'b1; cyc(1);
        end
        tx_we = 1'b0;
        chk("tx_full_set", tx_full, 1);
        cyc(100);
        chk("inh_clk_still_held", ps2_clk, 0);
        inhibit = 1'b0;
        cyc(50);
        chk("tx_popped_one", tx_full, 0);
        chk("tx_inh_clk_low", ps2_clk, 0);
        cyc(10010);
        chk("tx_req_data_low", ps2_data, 0);

        // Reset in the middle of a transmit
        RST_X = 1'b0;
        #2;
        chk("rst_mid_clk", ps2_clk, 1);
        chk("rst_mid_data", ps2_data, 1);
        chk("rst_mid_tx_full", tx_full, 0);
        chk("rst_mid_rx_empty", rx_empty, 1);
        chk("rst_mid_rx_count", rx_count, 0);
        chk("rst_mid_busy", busy, 0);
        cyc(3);
        RST_X = 1'b1;
        cyc(40);
        chk("rst_mid_stay_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
